param_sink: RTL
===============

PARAM_SINK -- requirements
Module: param_sink

Interface
REQ-001 Parameter K, default 0, signed 32-bit int; the expected value against which every accepted word is compared.
REQ-002 Parameter DEPTH, default 4; FIFO entries, power of two in 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  producer word valid; port default 0 when unconnected.
REQ-006 in_data  input  32 (int)  producer word; port default K when unconnected.
REQ-007 in_ready  output  1  sink can accept a word this cycle.
REQ-008 out_valid  output  1  FIFO head valid.
REQ-009 out_data  output  32  FIFO head word.
REQ-010 out_ready  input  1  consumer pops head; port default 1 when unconnected.
REQ-011 match_cnt  output  16  count of accepted words equal to K.
REQ-012 mismatch_cnt  output  16  count of accepted words not equal to K.
REQ-013 err  output  1  sticky; set by the first mismatch.
REQ-014 first_bad  output  32  value of the first mismatching word.
REQ-015 state  output  2  FSM state: 0 IDLE, 1 PASS, 2 FAIL.

Function
REQ-016 Push occurs when in_valid && in_ready; in_ready SHALL equal !full, with no dependence on out_ready.
REQ-017 Pop occurs when out_valid && out_ready; out_valid SHALL equal !empty; out_data SHALL be the oldest stored word.
REQ-018 A pushed word SHALL appear on out_data with out_valid=1 exactly one cycle after the push edge; there is no combinational bypass.
REQ-019 Simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
REQ-020 Occupancy SHALL be 0..DEPTH; pointers wrap modulo DEPTH; full when occupancy == DEPTH; empty when 0.
REQ-021 Each push SHALL compare in_data with K as a full 32-bit equality.
REQ-022 On a match push, match_cnt increments; on a mismatch push, mismatch_cnt increments; each saturates at 0xFFFF.
REQ-023 On the first mismatch push after reset, err SHALL go to 1 and first_bad SHALL capture in_data; later mismatches change neither.
REQ-024 FSM IDLE->PASS on the first match push; IDLE->FAIL or PASS->FAIL on any mismatch push; FAIL is held until reset.
REQ-025 With in_data unconnected and in_valid tied 1, every push SHALL count as a match.
REQ-026 Counters and err SHALL NOT depend on out_ready; a stalled consumer only stops pushes via in_ready.

Reset
REQ-027 While rst_n=0 at a clock edge, the following SHALL take these values: occupancy 0, out_valid 0, in_ready 1, out_data 0, match_cnt 0, mismatch_cnt 0, err 0, first_bad 0, state IDLE.
REQ-028 Reset asserted mid-transfer SHALL discard stored words; a push presented in the same cycle as reset is dropped and not counted.
REQ-029 Before the first clock edge with rst_n=0, outputs are unspecified.

Verification
REQ-030 K=1, push 1,1,0 with out_ready=1 -> match_cnt 2, mismatch_cnt 1, err 1, first_bad 0, state FAIL; out_data sequence 1,1,0.
REQ-031 K=0, DEPTH=4, out_ready=0, in_valid=1 for 6 cycles -> exactly 4 pushes, in_ready 0 from cycle 4, match_cnt 4.
REQ-032 Full FIFO, out_ready=1 for one cycle -> one pop, in_ready 1 next cycle, and the next push lands in the wrapped slot in order.
REQ-033 K=5, push 7 then 9 -> first_bad 7, mismatch_cnt 2, err stays 1 after 9.
REQ-034 in_data unconnected, K=3, in_valid=1 for 70000 cycles -> match_cnt saturates at 0xFFFF, state PASS.
REQ-035 Reset asserted with 3 words stored and a push pending -> next cycle out_valid 0, counters 0, state IDLE.

Source files
------------

// File: rtl/param_sink_if.sv
// param_sink_if -- stream bundle between a producer/consumer and param_sink.
//
// Handshake rule (both directions): a word moves on a rising clk edge when
// valid and ready are both high at that edge. valid may rise without waiting
// for ready. A producer holds data stable while valid is high and ready is low.
//
// Signals:
//   in_valid   producer -> sink  word offered (idles at 0 when nobody drives it)
//   in_data    producer -> sink  32-bit word (idles at K when nobody drives it)
//   in_ready   sink -> producer  FIFO not full
//   out_valid  sink -> consumer  FIFO head valid
//   out_data   sink -> consumer  FIFO head word
//   out_ready  consumer -> sink  pop head (idles at 1 when nobody drives it)
//
// Modports: master = producer/consumer side, slave = param_sink.
// K must match the K of the param_sink attached to this bundle, so that an
// undriven in_data reads as the expected value.
interface param_sink_if #(
  parameter int K = 0
);
  logic        in_valid  = 1'b0;
  logic [31:0] in_data   = 32'(K);
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b1;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/param_sink.sv
// param_sink -- FIFO sink that checks every accepted word against K.
//
// Each word accepted on the producer side is stored in a DEPTH-entry FIFO and
// compared with K. Match/mismatch counters saturate at 0xFFFF, err latches on
// the first mismatch and first_bad keeps that word. A small FSM summarises
// the run: IDLE (nothing seen), PASS (only matches so far), FAIL (any mismatch,
// held until reset).
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   bus           param_sink_if.slave stream bundle (producer in, consumer out)
//   match_cnt     accepted words equal to K
//   mismatch_cnt  accepted words not equal to K
//   err           sticky first-mismatch flag
//   first_bad     value of the first mismatching word
//   state         FSM state: 0 IDLE, 1 PASS, 2 FAIL
//
// DEPTH must be a power of two in 2..16 so pointers wrap by plain overflow.
module param_sink #(
  parameter int K     = 0,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  param_sink_if.slave        bus,
  output logic [15:0]        match_cnt,
  output logic [15:0]        mismatch_cnt,
  output logic               err,
  output logic [31:0]        first_bad,
  output logic [1:0]         state
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [31:0] K_VEC    = 32'(K);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_FAIL = 2'd2;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic is_match;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // in_ready looks only at occupancy; a stalled consumer throttles the
  // producer solely by letting the FIFO fill up.
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  // The storage array is not reset, so the head is masked to 0 while empty.
  assign bus.out_data  = empty ? 32'd0 : mem[rd_ptr];

  assign push     = bus.in_valid && !full;
  assign pop      = !empty && bus.out_ready;
  assign is_match = (bus.in_data == K_VEC);

  // Storage write; a push seen during reset is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  // Pointers and occupancy. Push and pop in the same cycle leave count alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Checker state: counters, sticky error and the summary FSM. All of it is
  // driven by pushes only, never by the consumer side.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match_cnt    <= 16'd0;
      mismatch_cnt <= 16'd0;
      err          <= 1'b0;
      first_bad    <= 32'd0;
      state        <= ST_IDLE;
    end else if (push) begin
      if (is_match) begin
        if (match_cnt != 16'hFFFF) begin
          match_cnt <= match_cnt + 16'd1;
        end
        // Only IDLE advances on a match; PASS stays PASS and FAIL is held.
        if (state == ST_IDLE) begin
          state <= ST_PASS;
        end
      end else begin
        if (mismatch_cnt != 16'hFFFF) begin
          mismatch_cnt <= mismatch_cnt + 16'd1;
        end
        if (!err) begin
          err       <= 1'b1;
          first_bad <= bus.in_data;
        end
        state <= ST_FAIL;
      end
    end
  end

endmodule
